// File: rtl/acq_popcount_seq_pkg.sv
// Shared definitions for the acquisition popcount sequencer:
// FSM state encodings and the parameter derivation helpers.
package acq_popcount_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of RUN cycles needed to cover a word of width w with the given lane count.
   function automatic int calc_iter(input int w, input int lanes);
      return w / (7 * lanes);
   endfunction

   // Result width able to hold a count of 0..w.
   function automatic int calc_sum_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Width of the per-cycle sum of all lane counts (0..7*lanes).
   function automatic int calc_lane_w(input int lanes);
      return $clog2(7 * lanes + 1);
   endfunction

endpackage

// File: rtl/acq_popcount_seq_lane_sum.sv
// acq_lane_sum: combinational sum of LANES 3-bit adder7 results.
module acq_lane_sum
   import acq_popcount_seq_pkg::*;
#(
   parameter  int LANES = 2,
   localparam int OUT_W = calc_lane_w(LANES)
) (
   input  logic [3*LANES-1:0] i_cnt,
   output logic [OUT_W-1:0]   o_sum
);

   // Add every lane count; the result width covers 7*LANES.
   always_comb begin
      o_sum = '0;
      for (int j = 0; j < LANES; j++) begin
         o_sum = o_sum + OUT_W'(i_cnt[j*3 +: 3]);
      end
   end

endmodule

// File: rtl/adder7.sv
// 7-input 1-bit adder: number of ones in a 7-bit slice (0..7).
module adder7 (
   input  logic [6:0] i_bits,
   output logic [2:0] o_cnt
);

   // Count the set bits of the slice.
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < 7; i++) begin
         o_cnt = o_cnt + 3'(i_bits[i]);
      end
   end

endmodule

// File: rtl/acq_popcount_seq.sv
// acq_popcount_seq: multi-cycle population count of a wide word.
// The word is latched (optionally inverted) and consumed LSB first,
// 7*LANES bits per cycle, through LANES adder7 lanes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a word, in_ready=1
// RUN     | counting one chunk per cycle, ITER cycles
// DONE    | result on out_sum, out_valid=1 until accepted; may accept
//         | the next word on the same edge as the output handshake
module acq_popcount_seq
   import acq_popcount_seq_pkg::*;
#(
   parameter  int IN_WIDTH = 56,
   parameter  int LANES    = 2,
   localparam int SUM_W    = calc_sum_w(IN_WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_invert,
   input  logic                abort,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SUM_W-1:0]    out_sum,
   output logic                busy
);

   localparam int ITER   = calc_iter(IN_WIDTH, LANES);
   localparam int LANE_W = calc_lane_w(LANES);
   localparam int CHUNK  = 7 * LANES;
   localparam int ITER_W = (ITER > 1) ? $clog2(ITER) : 1;

   if ((IN_WIDTH % CHUNK) != 0 || IN_WIDTH < CHUNK) begin : g_bad_width
      $error("acq_popcount_seq: IN_WIDTH must be a multiple of 7*LANES");
   end

   logic [1:0]          r_state;
   logic [IN_WIDTH-1:0] r_shreg;
   logic [ITER_W-1:0]   r_iter;
   logic [SUM_W-1:0]    r_acc;
   logic [SUM_W-1:0]    r_out_sum;
   logic                r_out_valid;
   logic                r_busy;

   logic [3*LANES-1:0]  w_lane_cnt;
   logic [LANE_W-1:0]   w_lane_total;
   logic [SUM_W-1:0]    w_acc_next;
   logic                w_accept;
   logic                w_out_hs;
   logic                w_last;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      adder7 u_adder7 (
         .i_bits (r_shreg[j*7 +: 7]),
         .o_cnt  (w_lane_cnt[j*3 +: 3])
      );
   end

   acq_lane_sum #(.LANES(LANES)) u_lane_sum (
      .i_cnt (w_lane_cnt),
      .o_sum (w_lane_total)
   );

   // Ready depends only on state and out_ready; abort still wins inside w_accept.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (r_state == ST_IDLE)
            in_ready = 1'b1;
         else if (r_state == ST_DONE)
            in_ready = out_ready;
      end
   end

   assign w_accept   = in_valid & in_ready & ~abort;
   assign w_out_hs   = r_out_valid & out_ready;
   assign w_acc_next = r_acc + SUM_W'(w_lane_total);
   assign w_last     = (r_iter == ITER_W'(ITER - 1));

   // FSM, shift register, iteration counter and accumulator.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_iter      <= '0;
         r_acc       <= '0;
         r_out_sum   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shreg <= in_data ^ {IN_WIDTH{in_invert}};
                  r_iter  <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_acc   <= w_acc_next;
               r_shreg <= r_shreg >> CHUNK;
               r_iter  <= r_iter + 1'b1;
               if (w_last) begin
                  r_out_sum   <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  if (w_accept) begin
                     r_shreg <= in_data ^ {IN_WIDTH{in_invert}};
                     r_iter  <= '0;
                     r_acc   <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign busy      = r_busy;

endmodule
